// File: rtl/split_solve_sched.sv
// Search scheduler: round-robin arbitration of NREQ requesters onto one shared
// constraint checker, walking an LFSR candidate stream per request.
module split_solve_sched #(
    parameter int               WIDTH     = 11,
    parameter int               NREQ      = 4,
    parameter int               MAX_TRIES = 1024,
    parameter logic [WIDTH-1:0] SEED      = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req,
    output logic [NREQ-1:0]                gnt,
    output logic                           rsp_valid,
    output logic                           rsp_ok,
    output logic [WIDTH-1:0]               rsp_value,
    output logic [$clog2(NREQ)-1:0]        rsp_id,
    output logic [WIDTH-1:0]               cand,
    output logic                           cand_valid,
    input  logic                           chk_pass,
    output logic                           busy,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries
);
    localparam int               IW       = $clog2(NREQ);
    localparam int               TW       = $clog2(MAX_TRIES + 1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? ONE : SEED;
    localparam logic [TW-1:0]    TRY_LAST = TW'(MAX_TRIES - 1);
    localparam logic [IW-1:0]    ID_LAST  = IW'(NREQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_RESP} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] w_lfsr_next;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_id;
    logic [TW-1:0]    r_tries;
    logic [WIDTH-1:0] r_rsp_value;
    logic             r_rsp_ok;
    logic             w_any;
    logic [IW-1:0]    w_pick;
    int               w_idx;
    logic             w_last_try;

    assign w_lfsr_next = {r_lfsr[WIDTH-2:0], r_lfsr[WIDTH-1] ^ r_lfsr[WIDTH-3]};
    assign w_last_try  = (r_tries == TRY_LAST);

    // Scan downward so the lowest offset from the pointer is the final winner.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (req[w_idx]) begin
                w_any  = 1'b1;
                w_pick = IW'(w_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any) w_state_next = S_SEARCH;
            S_SEARCH: if (chk_pass || w_last_try) w_state_next = S_RESP;
            S_RESP:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // The LFSR advances on every failed candidate, including the last one of a
    // timed-out search, and is never reseeded between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr      <= SEED_EFF;
            r_ptr       <= '0;
            r_id        <= '0;
            r_tries     <= '0;
            r_rsp_value <= '0;
            r_rsp_ok    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id    <= w_pick;
                        r_tries <= '0;
                    end
                end
                S_SEARCH: begin
                    if (chk_pass) begin
                        r_rsp_value <= r_lfsr;
                        r_rsp_ok    <= 1'b1;
                    end else begin
                        r_lfsr <= w_lfsr_next;
                        if (w_last_try) begin
                            r_rsp_value <= r_lfsr;
                            r_rsp_ok    <= 1'b0;
                        end else begin
                            r_tries <= r_tries + 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    r_ptr <= (r_id == ID_LAST) ? '0 : r_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cand_valid = (r_state == S_SEARCH);
        cand       = (r_state == S_SEARCH) ? r_lfsr : '0;
        rsp_valid  = (r_state == S_RESP);
        rsp_id     = (r_state == S_RESP) ? r_id : '0;
        busy       = (r_state != S_IDLE);
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
        assign gnt[gi] = (r_state == S_RESP) && (r_id == IW'(gi));
    end

    assign rsp_value = r_rsp_value;
    assign rsp_ok    = r_rsp_ok;
    assign tries     = r_tries;

endmodule

// File: tb/tb_split_solve_sched.sv
// Directed bench for split_solve_sched: a transaction-level model checks every
// cycle of the main instance; a second instance exercises the full LFSR period.
module tb_split_solve_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  req_a = 4'b0, gnt_a;
    logic        rsp_valid_a, rsp_ok_a, cand_valid_a, chk_pass_a, busy_a;
    logic [10:0] rsp_value_a, cand_a;
    logic [1:0]  rsp_id_a;
    logic [3:0]  tries_a;

    logic [3:0]  req_b = 4'b0, gnt_b;
    logic        rsp_valid_b, rsp_ok_b, cand_valid_b, chk_pass_b, busy_b;
    logic [10:0] rsp_value_b, cand_b;
    logic [1:0]  rsp_id_b;
    logic [11:0] tries_b;

    int          chk_mode = 0;          // 0: always fail, 1: always pass, 2: pass on target
    logic [10:0] chk_target = 11'h0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign chk_pass_a = (chk_mode == 1) || (chk_mode == 2 && cand_a == chk_target);
    assign chk_pass_b = 1'b0;

    split_solve_sched #(.WIDTH(11), .NREQ(4), .MAX_TRIES(8), .SEED(11'h001)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a),
        .rsp_valid(rsp_valid_a), .rsp_ok(rsp_ok_a), .rsp_value(rsp_value_a),
        .rsp_id(rsp_id_a), .cand(cand_a), .cand_valid(cand_valid_a),
        .chk_pass(chk_pass_a), .busy(busy_a), .tries(tries_a)
    );

    split_solve_sched #(.WIDTH(11), .NREQ(4), .MAX_TRIES(2048), .SEED(11'h001)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b),
        .rsp_valid(rsp_valid_b), .rsp_ok(rsp_ok_b), .rsp_value(rsp_value_b),
        .rsp_id(rsp_id_b), .cand(cand_b), .cand_valid(cand_valid_b),
        .chk_pass(chk_pass_b), .busy(busy_b), .tries(tries_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [10:0] lfsr_step(input logic [10:0] v);
        return {v[9:0], v[10] ^ v[8]};
    endfunction

    function automatic logic pred(input logic [10:0] v);
        return (chk_mode == 1) || (chk_mode == 2 && v == chk_target);
    endfunction

    // Transaction model: at grant time the whole candidate list of the search
    // is computed, then the cycles are checked against it one by one.
    int          m_phase = 0;
    bit          m_live  = 1'b0;
    int          m_ptr   = 0;
    int          m_id    = 0;
    int          m_i     = 0;
    logic        m_ok    = 1'b0;
    logic [10:0] m_lfsr  = 11'h001;
    logic [10:0] m_cands[$];
    logic [3:0]  m_one   = 4'b0001;

    always @(negedge clk) begin
        if (m_live) begin
            case (m_phase)
                0: begin
                    check("idle_cand_valid", 32'(cand_valid_a), 32'(0));
                    check("idle_busy",       32'(busy_a),       32'(0));
                    check("idle_rsp_valid",  32'(rsp_valid_a),  32'(0));
                    check("idle_gnt",        32'(gnt_a),        32'(0));
                end
                1: begin
                    check("srch_cand_valid", 32'(cand_valid_a), 32'(1));
                    check("srch_busy",       32'(busy_a),       32'(1));
                    check("srch_rsp_valid",  32'(rsp_valid_a),  32'(0));
                    check("srch_cand",       32'(cand_a),       32'(m_cands[m_i]));
                    check("srch_tries",      32'(tries_a),      32'(m_i));
                end
                default: begin
                    check("resp_valid", 32'(rsp_valid_a), 32'(1));
                    check("resp_gnt",   32'(gnt_a),       32'(m_one << m_id));
                    check("resp_id",    32'(rsp_id_a),    32'(m_id));
                    check("resp_ok",    32'(rsp_ok_a),    32'(m_ok));
                    check("resp_value", 32'(rsp_value_a), 32'(m_cands[m_cands.size()-1]));
                    check("resp_busy",  32'(busy_a),      32'(1));
                    check("resp_cv",    32'(cand_valid_a), 32'(0));
                    check("resp_tries", 32'(tries_a),     32'(m_cands.size() - 1));
                    $display("txn A: id=%0d ok=%0d value=0x%03h cands=%0d",
                             rsp_id_a, rsp_ok_a, rsp_value_a, m_cands.size());
                end
            endcase
        end
        if (rst) begin
            m_live  = 1'b1;
            m_phase = 0;
            m_lfsr  = 11'h001;
            m_ptr   = 0;
        end else if (m_live) begin
            case (m_phase)
                0: begin
                    if (req_a != 4'b0) begin
                        for (int i = 3; i >= 0; i--) begin
                            if (req_a[(m_ptr + i) % 4]) m_id = (m_ptr + i) % 4;
                        end
                        m_cands.delete();
                        m_ok = 1'b0;
                        for (int i = 0; i < 8; i++) begin
                            m_cands.push_back(m_lfsr);
                            if (pred(m_lfsr)) begin
                                m_ok = 1'b1;
                                break;
                            end
                            m_lfsr = lfsr_step(m_lfsr);
                        end
                        m_i     = 0;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_i++;
                    if (m_i == m_cands.size()) m_phase = 2;
                end
                default: begin
                    m_ptr   = (m_id + 1) % 4;
                    m_phase = 0;
                end
            endcase
        end
    end

    // Called at posedge+1; returns at posedge+1 after the response, with the
    // granted request bit dropped.
    task automatic wait_rsp(output int id, output int ncv, output logic [10:0] first);
        id = -1; ncv = 0; first = 11'h0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (cand_valid_a) begin
                if (ncv == 0) first = cand_a;
                ncv++;
            end
            if (rsp_valid_a) begin
                id = int'(rsp_id_a);
                break;
            end
        end
        if (id < 0) begin
            n_total++;
            $display("FAIL rsp_timeout: got no rsp_valid expected one within 100 cycles");
        end
        @(posedge clk); #1;
        if (id >= 0) req_a[id] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    int          id, ncv, dup, ncv_b, gnt_seen_b;
    logic [10:0] first;
    logic [10:0] cands_b[2048];
    bit          seen[2048];

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy",  32'(busy_a),      32'(0));
        check("rst_cv",    32'(cand_valid_a), 32'(0));
        check("rst_tries", 32'(tries_a),     32'(0));
        check("rst_ok",    32'(rsp_ok_a),    32'(0));
        check("rst_value", 32'(rsp_value_a), 32'(0));

        // Immediate pass, cycle-exact
        @(posedge clk); #1;
        chk_mode = 1; req_a = 4'b0100;
        @(negedge clk);
        check("imm_c0_cv", 32'(cand_valid_a), 32'(0));
        @(negedge clk);
        check("imm_c1_cv",   32'(cand_valid_a), 32'(1));
        check("imm_c1_cand", 32'(cand_a),       32'(11'h001));
        @(negedge clk);
        check("imm_c2_valid", 32'(rsp_valid_a), 32'(1));
        check("imm_c2_gnt",   32'(gnt_a),       32'(4'b0100));
        check("imm_c2_id",    32'(rsp_id_a),    32'(2));
        check("imm_c2_ok",    32'(rsp_ok_a),    32'(1));
        check("imm_c2_value", 32'(rsp_value_a), 32'(11'h001));
        @(posedge clk); #1;
        req_a = 4'b0;

        // Delayed pass
        do_reset();
        chk_mode = 2; chk_target = 11'h004; req_a = 4'b0001;
        wait_rsp(id, ncv, first);
        check("dly_id",    32'(id),          32'(0));
        check("dly_ncv",   32'(ncv),         32'(3));
        check("dly_first", 32'(first),       32'(11'h001));
        check("dly_ok",    32'(rsp_ok_a),    32'(1));
        check("dly_value", 32'(rsp_value_a), 32'(11'h004));
        check("dly_tries", 32'(tries_a),     32'(2));

        // Timeout after 8 candidates; the LFSR continues at 0x100
        do_reset();
        chk_mode = 0; req_a = 4'b0010;
        wait_rsp(id, ncv, first);
        check("to_id",    32'(id),          32'(1));
        check("to_ncv",   32'(ncv),         32'(8));
        check("to_ok",    32'(rsp_ok_a),    32'(0));
        check("to_value", 32'(rsp_value_a), 32'(11'h080));
        check("to_tries", 32'(tries_a),     32'(7));
        chk_mode = 1; req_a = 4'b0001;
        wait_rsp(id, ncv, first);
        check("to_next_id",   32'(id),    32'(0));
        check("to_next_cand", 32'(first), 32'(11'h100));

        // Round robin
        do_reset();
        chk_mode = 1; req_a = 4'b1011;
        wait_rsp(id, ncv, first); check("rr_0", 32'(id), 32'(0));
        wait_rsp(id, ncv, first); check("rr_1", 32'(id), 32'(1));
        wait_rsp(id, ncv, first); check("rr_2", 32'(id), 32'(3));
        req_a = 4'b0001;
        wait_rsp(id, ncv, first); check("rr_3", 32'(id), 32'(0));
        req_a = 4'b0101;
        wait_rsp(id, ncv, first); check("rr_4", 32'(id), 32'(2));
        wait_rsp(id, ncv, first); check("rr_5", 32'(id), 32'(0));

        // Reset mid-search
        chk_mode = 0; req_a = 4'b0100;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1; req_a = 4'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("ab_busy", 32'(busy_a),       32'(0));
            check("ab_cv",   32'(cand_valid_a), 32'(0));
            check("ab_rv",   32'(rsp_valid_a),  32'(0));
        end
        @(posedge clk); #1;
        chk_mode = 1; req_a = 4'b0001;
        wait_rsp(id, ncv, first);
        check("ab_first", 32'(first), 32'(11'h001));

        // Full LFSR period on the 2048-try instance
        req_b = 4'b0001;
        ncv_b = 0; gnt_seen_b = -1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (cand_valid_b) begin
                if (ncv_b < 2048) cands_b[ncv_b] = cand_b;
                ncv_b++;
            end
            if (rsp_valid_b) begin
                gnt_seen_b = int'(gnt_b);
                break;
            end
        end
        $display("txn B: gnt=%0d ok=%0d value=0x%03h cands=%0d",
                 gnt_seen_b, rsp_ok_b, rsp_value_b, ncv_b);
        @(posedge clk); #1;
        req_b = 4'b0;
        check("per_ncv",   32'(ncv_b),       32'(2048));
        check("per_gnt",   32'(gnt_seen_b),  32'(1));
        check("per_ok",    32'(rsp_ok_b),    32'(0));
        check("per_value", 32'(rsp_value_b), 32'(11'h001));
        dup = 0;
        for (int i = 0; i < 2047; i++) begin
            if (cands_b[i] == 11'h0 || seen[cands_b[i]]) dup++;
            seen[cands_b[i]] = 1'b1;
        end
        check("per_distinct", 32'(dup),         32'(0));
        check("per_first",    32'(cands_b[0]),   32'(11'h001));
        check("per_wrap",     32'(cands_b[2047]), 32'(11'h001));

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before 1ms");
        $fatal(1, "watchdog");
    end
endmodule
